// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: widths, NOP encoding, opcode constants
// and the fetch-stage state type.
package mips_pkg;

    localparam int DEFAULT_ADDR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_t;

    function automatic logic [5:0] getOpcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read port: one outstanding req/ack transaction at a time.
interface if_stage_if #(
    parameter int ADDR_W = 32
) ();

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Load takes priority over bubble; with neither asserted
// the register holds its contents. A bubble leaves pcPlus4 untouched.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic [31:0]       instrIn,
    input  logic [ADDR_W-1:0] pcPlus4In,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pcPlus4
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            instr   <= NOP_INSTR;
            pcPlus4 <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= instrIn;
            pcPlus4 <= pcPlus4In;
        end else if (bubble) begin
            valid   <= 1'b0;
            instr   <= NOP_INSTR;
        end
    end

    assign opcode = getOpcode(instr);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding reads to instruction
// memory and feeds the IF/ID register, handling decode stalls and branch redirects.
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    if_stage_if.master        imem,
    input  logic              stall,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [5:0]        ifid_opcode,
    output logic [ADDR_W-1:0] ifid_pc_plus4
);

    if_state_t         state;
    if_state_t         nextState;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pendTarget;
    logic [31:0]       skidBuf;
    logic              reqOut;
    logic              ifLoad;
    logic              ifBubble;
    logic [31:0]       ifInstr;
    logic              bufLoad;
    logic              pendLoad;

    assign pcPlus4 = pc + ADDR_W'(4);
    assign target  = branch_target & ~ADDR_W'(3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  nextState = FETCH;
            FETCH: begin
                if (imem.ack && !pc_src && stall) begin
                    nextState = HOLD;
                end else if (!imem.ack && pc_src) begin
                    nextState = DRAIN;
                end
            end
            HOLD: begin
                if (pc_src || !stall) begin
                    nextState = FETCH;
                end
            end
            DRAIN: begin
                if (imem.ack) begin
                    nextState = FETCH;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A redirect always wins over a stall; in DRAIN the newest target is the one used.
    always_comb begin
        reqOut   = 1'b0;
        ifLoad   = 1'b0;
        ifBubble = 1'b0;
        ifInstr  = imem.rdata;
        pcNext   = pc;
        bufLoad  = 1'b0;
        pendLoad = 1'b0;
        unique case (state)
            IDLE: begin
            end
            FETCH: begin
                reqOut = 1'b1;
                if (imem.ack) begin
                    if (pc_src) begin
                        pcNext   = target;
                        ifBubble = 1'b1;
                    end else if (!stall) begin
                        ifLoad = 1'b1;
                        pcNext = pcPlus4;
                    end else begin
                        bufLoad = 1'b1;
                    end
                end else if (pc_src) begin
                    pendLoad = 1'b1;
                    ifBubble = 1'b1;
                end else if (!stall) begin
                    ifBubble = 1'b1;
                end
            end
            HOLD: begin
                if (pc_src) begin
                    pcNext   = target;
                    ifBubble = 1'b1;
                end else if (!stall) begin
                    ifLoad  = 1'b1;
                    ifInstr = skidBuf;
                    pcNext  = pcPlus4;
                end
            end
            DRAIN: begin
                reqOut   = 1'b1;
                ifBubble = 1'b1;
                pendLoad = pc_src;
                if (imem.ack) begin
                    pcNext = pc_src ? target : pendTarget;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            skidBuf    <= NOP_INSTR;
            pendTarget <= RESET_PC;
        end else begin
            pc <= pcNext;
            if (bufLoad) begin
                skidBuf <= imem.rdata;
            end
            if (pendLoad) begin
                pendTarget <= target;
            end
        end
    end

    assign imem.req  = reqOut;
    assign imem.addr = pc;

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) ifIdReg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifLoad),
        .bubble    (ifBubble),
        .instrIn   (ifInstr),
        .pcPlus4In (pcPlus4),
        .valid     (ifid_valid),
        .instr     (ifid_instr),
        .opcode    (ifid_opcode),
        .pcPlus4   (ifid_pc_plus4)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a transaction-level fetch model is checked against
// the DUT every cycle, with hand-computed literals pinning key points.
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_opcode;
    logic [31:0] ifid_pc_plus4;

    if_stage_if #(.ADDR_W(32)) imemBus ();

    if_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imemBus),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_opcode   (ifid_opcode),
        .ifid_pc_plus4 (ifid_pc_plus4)
    );

    always #5 clk = ~clk;

    int  nVec = 0;
    int  nMis = 0;
    bit  checkEn = 1'b0;

    // Model: fetch activity described as "started", "holding a fetched word" and
    // "waiting to discard a read because a redirect arrived".
    bit          mStarted, mHolding, mDropping, mReq, mValid;
    logic [31:0] mPc, mPend, mBuf, mInstr, mPc4;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h8) return 32'h8C01_0004;
        return {6'h08, a[25:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nMis++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic deliver(input logic [31:0] w);
        mValid = 1'b1;
        mInstr = w;
        mPc4   = mPc + 32'd4;
        mPc    = mPc + 32'd4;
    endtask

    task automatic modelStep(input bit rstn, input bit ack, input logic [31:0] rd,
                             input bit st, input bit ps, input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (!rstn) begin
            mStarted = 0; mHolding = 0; mDropping = 0; mValid = 0;
            mPc = 32'h0; mPend = 32'h0; mBuf = 32'h0; mInstr = 32'h0; mPc4 = 32'h0;
        end else if (!mStarted) begin
            mStarted = 1;
        end else if (mHolding) begin
            if (ps) begin
                mPc = t; mValid = 0; mInstr = 32'h0; mHolding = 0;
            end else if (!st) begin
                deliver(mBuf); mHolding = 0;
            end
        end else if (mDropping) begin
            if (ps) mPend = t;
            if (ack) begin
                mPc = mPend; mDropping = 0;
            end
        end else if (ack) begin
            if (ps) begin
                mPc = t; mValid = 0; mInstr = 32'h0;
            end else if (!st) begin
                deliver(rd);
            end else begin
                mBuf = rd; mHolding = 1;
            end
        end else if (ps) begin
            mPend = t; mValid = 0; mInstr = 32'h0; mDropping = 1;
        end else if (!st) begin
            mValid = 0; mInstr = 32'h0;
        end
        mReq = mStarted && !mHolding;
    endtask

    task automatic applyStimulus(input bit rstn, input bit ack, input bit st,
                                 input bit ps, input logic [31:0] tgt);
        logic [31:0] rd;
        rd = ack ? memWord(mPc) : 32'hDEAD_BEEF;
        rst_n         = rstn;
        imemBus.ack   = ack;
        imemBus.rdata = rd;
        stall         = st;
        pc_src        = ps;
        branch_target = tgt;
        @(posedge clk);
        modelStep(rstn, ack, rd, st, ps, tgt);
        if (!rstn) checkEn = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("imem_req", 32'(imemBus.req), 32'(mReq));
            if (mReq) checkOutput("imem_addr", imemBus.addr, mPc);
            checkOutput("ifid_valid", 32'(ifid_valid), 32'(mValid));
            checkOutput("ifid_instr", ifid_instr, mInstr);
            checkOutput("ifid_opcode", 32'(ifid_opcode), 32'(mInstr[31:26]));
            checkOutput("ifid_pc_plus4", ifid_pc_plus4, mPc4);
        end
    end

    initial begin
        mPc = 32'h0;
        imemBus.ack = 1'b0;
        imemBus.rdata = 32'h0;

        // Reset, then zero-wait memory streaming 0,4,8,12,16
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit_reset_req", 32'(imemBus.req), 32'h0);
        checkOutput("lit_reset_addr", imemBus.addr, 32'h0);
        checkOutput("lit_reset_valid", 32'(ifid_valid), 32'h0);
        checkOutput("lit_reset_instr", ifid_instr, 32'h0);
        checkOutput("lit_reset_pc4", ifid_pc_plus4, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("lit_first_req", 32'(imemBus.req), 32'h1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("lit_stream_addr", imemBus.addr, 32'h14);
        checkOutput("lit_stream_pc4", ifid_pc_plus4, 32'h14);
        checkOutput("lit_stream_instr", ifid_instr, 32'h2000_0010);

        // Slow memory: ack after 3 wait cycles, then a stall with no request pending
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 1, 0, 32'h0);
        checkOutput("lit_wait_addr", imemBus.addr, 32'h14);
        applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("lit_slow_instr", ifid_instr, 32'h2000_0014);
        checkOutput("lit_slow_addr", imemBus.addr, 32'h18);
        applyStimulus(1, 0, 1, 0, 32'h0);
        checkOutput("lit_stall_hold_valid", 32'(ifid_valid), 32'h1);

        // Stall on the ack of address 8 -> HOLD, then release
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 0, 32'h0);
        checkOutput("lit_hold_req", 32'(imemBus.req), 32'h0);
        checkOutput("lit_hold_instr", ifid_instr, 32'h2000_0004);
        applyStimulus(1, 1, 1, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("lit_release_instr", ifid_instr, 32'h8C01_0004);
        checkOutput("lit_release_opcode", 32'(ifid_opcode), 32'(OP_LW));
        checkOutput("lit_release_addr", imemBus.addr, 32'hC);

        // Redirect on the ack cycle
        applyStimulus(1, 1, 0, 1, 32'h40);
        checkOutput("lit_redirect_valid", 32'(ifid_valid), 32'h0);
        checkOutput("lit_redirect_addr", imemBus.addr, 32'h40);
        checkOutput("lit_redirect_pc4", ifid_pc_plus4, 32'hC);
        applyStimulus(1, 1, 0, 0, 32'h0);

        // Redirect while unacked -> DRAIN, second redirect wins
        applyStimulus(1, 0, 0, 1, 32'h80);
        checkOutput("lit_drain_addr", imemBus.addr, 32'h44);
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 1, 1, 32'hA0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("lit_drain_target", imemBus.addr, 32'hA0);
        checkOutput("lit_drain_valid", 32'(ifid_valid), 32'h0);

        // PC wrap, target alignment, reset mid-request, stray ack in IDLE
        applyStimulus(1, 1, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("lit_wrap_addr", imemBus.addr, 32'h0);
        checkOutput("lit_wrap_pc4", ifid_pc_plus4, 32'h0);
        checkOutput("lit_wrap_instr", ifid_instr, 32'h23FF_FFFC);
        applyStimulus(1, 1, 0, 1, 32'h43);
        checkOutput("lit_align_addr", imemBus.addr, 32'h40);
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("lit_midreset_req", 32'(imemBus.req), 32'h0);
        checkOutput("lit_midreset_valid", 32'(ifid_valid), 32'h0);
        checkOutput("lit_midreset_pc4", ifid_pc_plus4, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("lit_stray_valid", 32'(ifid_valid), 32'h0);
        checkOutput("lit_stray_addr", imemBus.addr, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        checkOutput("lit_after_reset_instr", ifid_instr, 32'h2000_0000);

        // Redirect overrides stall while holding a fetched word
        applyStimulus(1, 1, 1, 0, 32'h0);
        applyStimulus(1, 0, 1, 1, 32'h100);
        checkOutput("lit_override_addr", imemBus.addr, 32'h100);
        checkOutput("lit_override_req", 32'(imemBus.req), 32'h1);
        applyStimulus(1, 1, 0, 0, 32'h0);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
